// File: rtl/dc2_expun_ctrl.sv
// L2 tag-array init sweep plus victim expunge queue toward writeback.
// Build option DC2_CLEAN_EXPUN_EN also queues clean victims.
module dc2_expun_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 36
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init,
  output logic [7:0]        initCount,
  output logic              init_done,
  input  logic              flush_req,
  input  logic              exp_en,
  input  logic              exp_hitE,
  input  logic              exp_hitO,
  input  logic              exp_dirE,
  input  logic              exp_dirO,
  input  logic [ADDR_W-1:0] exp_addrE,
  input  logic [ADDR_W-1:0] exp_addrO,
  output logic              exp_stall,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_odd,
  output logic              wb_dirty
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 2);

`ifdef DC2_CLEAN_EXPUN_EN
  localparam logic CLEAN = 1'b1;
`else
  localparam logic CLEAN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q  [FIFO_DEPTH];
  logic              odd_q   [FIFO_DEPTH];
  logic              dirty_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, wr_ptr_o, rd_ptr;
  logic [CW-1:0]     count, count_nx;
  logic              take, push_e, push_o, pop;

  assign init      = (state == S_INIT);
  assign init_done = (state != S_INIT);
  assign initCount = cnt_q;

  // Stall looks only at registered state so it never depends on wb_ready.
  assign exp_stall = (state != S_IDLE) || (count > STALL_LVL);

  assign take   = (state == S_IDLE) && exp_en && !exp_stall;
  assign push_e = take && exp_hitE && (exp_dirE || CLEAN);
  assign push_o = take && exp_hitO && (exp_dirO || CLEAN);

  assign wb_valid = (count != '0);
  assign pop      = wb_valid && wb_ready;

  assign count_nx = count + CW'(push_e) + CW'(push_o) - CW'(pop);
  assign wr_ptr_o = wr_ptr + PW'(push_e);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:  if (cnt_q == 8'hFF) state_nx = S_IDLE;
      S_IDLE:  if (flush_req)
                 state_nx = (count == '0) ? S_INIT : S_DRAIN;
      S_DRAIN: if (count_nx == '0) state_nx = S_INIT;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_INIT;
      cnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) cnt_q <= cnt_q + 8'd1;
      else                 cnt_q <= '0;
      wr_ptr <= wr_ptr + PW'(push_e) + PW'(push_o);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
    end
  end

  // Even entry lands first so it reaches the head before the odd one.
  always_ff @(posedge clk) begin
    if (push_e) begin
      addr_q[wr_ptr]  <= exp_addrE;
      odd_q[wr_ptr]   <= 1'b0;
      dirty_q[wr_ptr] <= exp_dirE;
    end
    if (push_o) begin
      addr_q[wr_ptr_o]  <= exp_addrO;
      odd_q[wr_ptr_o]   <= 1'b1;
      dirty_q[wr_ptr_o] <= exp_dirO;
    end
  end

  assign wb_addr  = wb_valid ? addr_q[rd_ptr]  : '0;
  assign wb_odd   = wb_valid ? odd_q[rd_ptr]   : 1'b0;
  assign wb_dirty = wb_valid ? dirty_q[rd_ptr] : 1'b0;

  a_no_en_when_stalled: assert property (
    @(posedge clk) disable iff (rst) !(exp_en && exp_stall)
  );

endmodule

// File: tb/tb_dc2_expun_ctrl.sv
// Bench for dc2_expun_ctrl: queue/sweep model plus directed literals.
// Honours DC2_CLEAN_EXPUN_EN the same way as the design.
module tb_dc2_expun_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 36;

`ifdef DC2_CLEAN_EXPUN_EN
  localparam bit CLEAN = 1'b1;
`else
  localparam bit CLEAN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          init;
  logic [7:0]    initCount;
  logic          init_done;
  logic          flush_req;
  logic          exp_en;
  logic          exp_hitE, exp_hitO;
  logic          exp_dirE, exp_dirO;
  logic [AW-1:0] exp_addrE, exp_addrO;
  logic          exp_stall;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic          wb_odd;
  logic          wb_dirty;

  dc2_expun_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .initCount (initCount),
    .init_done (init_done),
    .flush_req (flush_req),
    .exp_en    (exp_en),
    .exp_hitE  (exp_hitE),
    .exp_hitO  (exp_hitO),
    .exp_dirE  (exp_dirE),
    .exp_dirO  (exp_dirO),
    .exp_addrE (exp_addrE),
    .exp_addrO (exp_addrO),
    .exp_stall (exp_stall),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_odd    (wb_odd),
    .wb_dirty  (wb_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic          o;
    logic          d;
  } ent_t;

  ent_t q[$];
  int   sweep_left = 256;
  bit   pend       = 1'b0;
  bit   chk_en     = 1'b0;

  function automatic bit m_stall();
    return (sweep_left > 0) || pend || ((DEPTH - q.size()) < 2);
  endfunction

  always @(posedge clk) begin : model
    bit st;
    int n0;
    if (rst) begin
      q.delete();
      sweep_left = 256;
      pend       = 1'b0;
      chk_en     = 1'b1;
    end else begin
      st = m_stall();
      n0 = q.size();
      if (n0 != 0 && wb_ready) void'(q.pop_front());
      if (sweep_left > 0) begin
        sweep_left--;
      end else if (!pend) begin
        if (exp_en && !st) begin
          if (exp_hitE && (exp_dirE || CLEAN))
            q.push_back('{exp_addrE, 1'b0, exp_dirE});
          if (exp_hitO && (exp_dirO || CLEAN))
            q.push_back('{exp_addrO, 1'b1, exp_dirO});
        end
        if (flush_req) begin
          if (n0 == 0) sweep_left = 256;
          else         pend = 1'b1;
        end
      end else if (q.size() == 0) begin
        pend       = 1'b0;
        sweep_left = 256;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_init", init, sweep_left > 0);
      if (sweep_left > 0)
        chk("m_initCount", initCount, 256 - sweep_left);
      chk("m_init_done", init_done, sweep_left == 0);
      chk("m_stall", exp_stall, m_stall());
      chk("m_wb_valid", wb_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_wb_addr", wb_addr, q[0].a);
        chk("m_wb_odd", wb_odd, q[0].o);
        chk("m_wb_dirty", wb_dirty, q[0].d);
      end else begin
        chk("m_wb_addr0", wb_addr, 0);
        chk("m_wb_odd0", wb_odd, 0);
        chk("m_wb_dirty0", wb_dirty, 0);
      end
    end
  end

  task automatic vic(input bit he, input bit de,
                     input bit ho, input bit dO,
                     input logic [AW-1:0] ae,
                     input logic [AW-1:0] ao);
    exp_en    = 1'b1;
    exp_hitE  = he;
    exp_dirE  = de;
    exp_hitO  = ho;
    exp_dirO  = dO;
    exp_addrE = ae;
    exp_addrO = ao;
    @(negedge clk);
    exp_en   = 1'b0;
    exp_hitE = 1'b0;
    exp_dirE = 1'b0;
    exp_hitO = 1'b0;
    exp_dirO = 1'b0;
  endtask

  logic [AW-1:0] fa [4];
  int ok;

  initial begin
    fa[0] = 36'h111111111;
    fa[1] = 36'h222222222;
    fa[2] = 36'h333333333;
    fa[3] = 36'h444444444;
    rst = 1'b1;
    flush_req = 1'b0;
    exp_en = 1'b0;
    exp_hitE = 1'b0;
    exp_hitO = 1'b0;
    exp_dirE = 1'b0;
    exp_dirO = 1'b0;
    exp_addrE = '0;
    exp_addrO = '0;
    wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_init", init, 1);
    chk("rst_initCount", initCount, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall", exp_stall, 1);
    rst = 1'b0;

    ok = 0;
    for (int k = 0; k < 256; k++) begin
      if (init && initCount == 8'(k)) ok++;
      @(negedge clk);
    end
    chk("sweep_cycles", ok, 256);
    chk("sweep_end_init", init, 0);
    chk("sweep_done", init_done, 1);
    chk("sweep_stall", exp_stall, 0);

    vic(1, 1, 1, 1, 36'h123456789, 36'h0ABCDEF01);
    chk("cap_valid", wb_valid, 1);
    chk("cap_addrE", wb_addr, 36'h123456789);
    chk("cap_oddE", wb_odd, 0);
    chk("cap_dirty", wb_dirty, 1);
    chk("cap_stall", exp_stall, 0);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("cap_addrO", wb_addr, 36'h0ABCDEF01);
    chk("cap_oddO", wb_odd, 1);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("cap_empty", wb_valid, 0);

    vic(1, 1, 1, 1, fa[0], fa[1]);
    vic(1, 1, 1, 1, fa[2], fa[3]);
    chk("full_stall", exp_stall, 1);
    chk("full_valid", wb_valid, 1);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_order", wb_addr, fa[i]);
      @(negedge clk);
    end
    wb_ready = 1'b0;
    chk("full_drained", wb_valid, 0);
    chk("full_unstall", exp_stall, 0);

    vic(1, 0, 0, 0, 36'h0000000F0, '0);
    chk("clean_valid", wb_valid, CLEAN);
    chk("clean_dirty", wb_dirty, 0);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("clean_gone", wb_valid, 0);

    vic(1, 1, 1, 1, 36'hA0000000A, 36'hB0000000B);
    vic(1, 1, 0, 0, 36'hC0000000C, '0);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("drain_stall", exp_stall, 1);
    chk("drain_noinit", init, 0);
    chk("drain_valid", wb_valid, 1);
    wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    wb_ready = 1'b0;
    chk("drain_init", init, 1);
    chk("drain_idx0", initCount, 0);
    chk("drain_empty", wb_valid, 0);
    repeat (256) @(negedge clk);
    chk("drain_done", init_done, 1);
    chk("drain_init_off", init, 0);

    exp_en = 1'b1;
    exp_hitE = 1'b1;
    exp_dirE = 1'b1;
    exp_hitO = 1'b1;
    exp_dirO = 1'b1;
    exp_addrE = 36'hD0000000D;
    exp_addrO = 36'hE0000000E;
    flush_req = 1'b1;
    @(negedge clk);
    exp_en = 1'b0;
    exp_hitE = 1'b0;
    exp_dirE = 1'b0;
    exp_hitO = 1'b0;
    exp_dirO = 1'b0;
    flush_req = 1'b0;
    chk("rsw_init", init, 1);
    chk("rsw_idx0", initCount, 0);
    chk("rsw_head", wb_addr, 36'hD0000000D);
    repeat (100) @(negedge clk);
    chk("rsw_idx100", initCount, 100);
    chk("rsw_queued", wb_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rsw_flushed", wb_valid, 0);
    chk("rsw_restart", initCount, 0);
    chk("rsw_init_on", init, 1);
    repeat (258) @(negedge clk);
    chk("rsw_done", init_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
